// File: rtl/key_press_reader.sv
// Debounced push-button reader: press/release strobes, press counter and
// whole-second hold timer with a one-shot long-press strobe.
module key_press_reader #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned SEC_CYCLES      = 50000000,
  parameter int unsigned LONG_SEC        = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       key_n,
  output logic       pressed,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       long_press,
  output logic [7:0] press_count,
  output logic [7:0] hold_seconds
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned SW = $clog2(SEC_CYCLES + 1);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SW-1:0] SEC_LAST = SW'(SEC_CYCLES - 1);
  localparam logic [7:0]    LONG_M1  = 8'(LONG_SEC - 1);

  typedef enum logic [1:0] {IDLE, DEB_PRESS, HELD, DEB_RELEASE} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [SW-1:0] presc;
  logic          sync1, key_s;
  logic          go_press, go_release;
  logic          hold_run;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= 1'b1;
      key_s <= 1'b1;
    end else begin
      sync1 <= key_n;
      key_s <= sync1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    go_press   = 1'b0;
    go_release = 1'b0;
    case (state)
      IDLE:
        if (!key_s) begin
          state_n = DEB_PRESS;
          cnt_n   = '0;
        end
      DEB_PRESS:
        if (key_s) begin
          state_n = IDLE;
        end else if (cnt == DEB_LAST) begin
          state_n  = HELD;
          go_press = 1'b1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      HELD:
        if (key_s) begin
          state_n = DEB_RELEASE;
          cnt_n   = '0;
        end
      DEB_RELEASE:
        if (!key_s) begin
          state_n = HELD;
        end else if (cnt == DEB_LAST) begin
          state_n    = IDLE;
          go_release = 1'b1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      default: state_n = IDLE;
    endcase
  end

  assign pressed = (state == HELD) || (state == DEB_RELEASE);

  // The release edge itself does not advance the timer, so a second tick
  // (and long_press) can never land on the same cycle as release_pulse.
  assign hold_run = pressed && !go_release;

  always_ff @(posedge clock) begin
    if (reset) begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_press    <= 1'b0;
      press_count   <= '0;
      hold_seconds  <= '0;
      presc         <= '0;
    end else begin
      press_pulse   <= go_press;
      release_pulse <= go_release;
      long_press    <= 1'b0;
      if (go_press) begin
        press_count  <= press_count + 8'd1;
        hold_seconds <= '0;
        presc        <= '0;
      end else if (hold_run) begin
        if (presc == SEC_LAST) begin
          presc <= '0;
          if (hold_seconds != 8'hFF) hold_seconds <= hold_seconds + 8'd1;
          long_press <= (hold_seconds == LONG_M1);
        end else begin
          presc <= presc + SW'(1);
        end
      end
    end
  end

endmodule
